writeback_buffer: RTL
=====================

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending register-write entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default `WORD (64), data width of one register write.
REQ-003 SHALL have port write_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 SHALL have port flush  input  1  synchronous discard of all pending entries.
REQ-006 SHALL have port in_valid  input  1  producer offers a register write this cycle.
REQ-007 SHALL have port in_ready  output  1  buffer accepts the offered write this cycle.
REQ-008 SHALL have port in_reg  input  5  destination register number.
REQ-009 SHALL have port in_data  input  WIDTH  value to write.
REQ-010 SHALL have port rf_stall  input  1  register file cannot take a write this cycle.
REQ-011 SHALL have port rf_reg_write  output  1  write strobe to register file.
REQ-012 SHALL have port rf_write_reg  output  5  register-file write address.
REQ-013 SHALL have port rf_write_data  output  WIDTH  register-file write data.
REQ-014 SHALL have ports lookup_reg1, lookup_reg2  input  5 each  decode-side read addresses for bypass.
REQ-015 SHALL have ports bypass_hit1, bypass_hit2  output  1 each  pending write exists for that address.
REQ-016 SHALL have ports bypass_data1, bypass_data2  output  WIDTH each  youngest pending value for that address.
REQ-017 SHALL have ports count  output  $clog2(DEPTH)+1  occupancy, and empty  output  1  count==0.

Function
REQ-018 SHALL be a circular FIFO with head pointer, tail pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = !flush && (count < DEPTH); no same-cycle pass-through when full.
REQ-020 SHALL enqueue {in_reg, in_data} at tail on an edge where in_valid && in_ready.
REQ-021 SHALL accept but silently drop writes with in_reg == 31 (XZR): handshake completes, no entry, count unchanged.
REQ-022 SHALL drive rf_reg_write = !empty && !rf_stall, and rf_write_reg/rf_write_data combinationally from the head entry (zero when empty).
REQ-023 SHALL pop head on an edge where rf_reg_write == 1; entries leave in strict arrival order.
REQ-024 SHALL give latency: entry enqueued at edge N appears on rf_* outputs after edge N, and is written at edge N+1 unless stalled.
REQ-025 SHALL handle simultaneous enqueue and pop: count unchanged, both pointers advance.
REQ-026 SHALL on flush clear count and pointers at the next edge, ignore in_valid, and hold rf_reg_write low for that cycle.
REQ-027 SHALL compute bypass_hitN = 1 iff some valid entry (including head) has reg == lookup_regN; bypass_dataN = data of youngest such entry; lookup_regN == 31 never hits; no hit -> data 0.
REQ-028 SHALL never let count exceed DEPTH or go below 0.

Reset
REQ-029 SHALL on reset asserted set head, tail, count to 0; entry storage need not be cleared.
REQ-030 SHALL during and after reset present in_ready=1 (flush low), rf_reg_write=0, rf_write_reg=0, rf_write_data=0, bypass_hit1/2=0, bypass_data1/2=0, count=0, empty=1.
REQ-031 SHALL, if reset asserts mid-operation, discard all pending entries; nothing written afterward.

Configuration
REQ-032 SHALL, with macro WB_BYPASS_EN defined, implement REQ-027 lookup logic.
REQ-033 SHALL, without WB_BYPASS_EN, tie bypass_hit1/2 and bypass_data1/2 to 0, keep ports present, and omit comparator logic; all other behaviour identical.

Verification
REQ-034 SHALL cover: after reset, enqueue (X5, 0x11) -> next cycle rf_reg_write=1, rf_write_reg=5, rf_write_data=0x11; then empty=1.
REQ-035 SHALL cover: rf_stall=1, enqueue 4 writes (X1..X4) -> count=4, in_ready=0, 5th offer not taken; release stall -> X1..X4 written in order on 4 consecutive edges.
REQ-036 SHALL cover: enqueue (X7,0xA) then (X7,0xB) under stall, lookup_reg1=7 -> bypass_hit1=1, bypass_data1=0xB; lookup_reg2=8 -> hit 0, data 0.
REQ-037 SHALL cover: in_valid with in_reg=31, data 0xFF -> in_ready=1, count stays 0, no rf write; lookup 31 -> no hit.
REQ-038 SHALL cover: full buffer, flush=1 with in_valid=1 -> in_ready=0, next edge count=0, no rf write that cycle; reset asserted mid-drain -> outputs per REQ-030 asynchronously.
REQ-039 SHALL cover: compiled without WB_BYPASS_EN, REQ-036 stimulus -> bypass_hit1=0, bypass_data1=0; write order unchanged.

Source files
------------

// File: rtl/writeback_buffer.sv
// writeback_buffer: circular FIFO of pending register-file writes between
// the execute/commit side and the register file. It drains one entry per
// cycle unless the register file stalls. Writes to X31 (XZR) complete the
// handshake but are dropped.
// Optional feature: define WB_BYPASS_EN to enable the decode-side bypass
// lookup. Without it, the bypass outputs are tied to zero.

`ifndef WORD
`define WORD 64
`endif

module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = `WORD
) (
    input  logic                     write_clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     rf_stall,
    output logic                     rf_reg_write,
    output logic [4:0]               rf_write_reg,
    output logic [WIDTH-1:0]         rf_write_data,
    input  logic [4:0]               lookup_reg1,
    input  logic [4:0]               lookup_reg2,
    output logic                     bypass_hit1,
    output logic                     bypass_hit2,
    output logic [WIDTH-1:0]         bypass_data1,
    output logic [WIDTH-1:0]         bypass_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0] XZR = 5'd31;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage is not reset; only entries inside [head, head+count) are ever observed.
    logic [4:0]       reg_mem_q  [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];

    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign in_ready = !flush && (count_q < CNT_W'(DEPTH));

    // An XZR write is accepted but never becomes an entry.
    assign push = in_valid && in_ready && (in_reg != XZR);

    // Flush blocks the register-file write for its cycle, so the pop is suppressed too.
    assign rf_reg_write  = !empty && !rf_stall && !flush;
    assign pop           = rf_reg_write;
    assign rf_write_reg  = empty ? 5'd0 : reg_mem_q[head_q];
    assign rf_write_data = empty ? '0   : data_mem_q[head_q];

    // Next-state for pointers and occupancy; flush overrides any traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: asynchronously cleared, updated every write_clk edge.
    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: written at the tail on an accepted, non-XZR write.
    always_ff @(posedge write_clk) begin
        if (push) begin
            reg_mem_q[tail_q]  <= in_reg;
            data_mem_q[tail_q] <= in_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match (the youngest) wins.
    function automatic logic [WIDTH:0] bypass_lookup(input logic [4:0] key);
        logic             hit;
        logic [WIDTH-1:0] dat;
        logic [PTR_W-1:0] idx;
        hit = 1'b0;
        dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (reg_mem_q[idx] == key) && (key != XZR)) begin
                hit = 1'b1;
                dat = data_mem_q[idx];
            end
        end
        return {hit, dat};
    endfunction

    // Decode-side bypass lookup for both read ports.
    always_comb begin
        {bypass_hit1, bypass_data1} = bypass_lookup(lookup_reg1);
        {bypass_hit2, bypass_data2} = bypass_lookup(lookup_reg2);
    end
`else
    logic unused_lookup;
    assign unused_lookup = &{1'b0, lookup_reg1, lookup_reg2};

    // Bypass disabled: ports stay present but are held at zero.
    always_comb begin
        bypass_hit1  = 1'b0;
        bypass_hit2  = 1'b0;
        bypass_data1 = '0;
        bypass_data2 = '0;
    end
`endif

endmodule
